// File: rtl/decoder_3x8_seq_if.sv
// Code-stream handshake bundle for decoder_3x8_seq.
// The master drives a 3-bit code with in_valid. The slave accepts it with in_ready.
`timescale 1ns/1ps
interface decoder_3x8_seq_if;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in;

  modport master (output in_valid, output in, input in_ready);
  modport slave  (input in_valid, input in, output in_ready);
endinterface

// File: rtl/decoder_3x8_seq.sv
// Sequenced 3-to-8 one-hot decoder: a FIFO of codes drained into timed one-hot pulses.
// Define DEC3X8_CNT_EN to add a saturating 8-bit count of emitted codes.
`timescale 1ns/1ps
module decoder_3x8_seq #(
  parameter int DEPTH     = 4,
  parameter int PULSE_LEN = 1,
  parameter int GAP_LEN   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  decoder_3x8_seq_if.slave bus,
  output logic [7:0]       out,
  output logic             busy
`ifdef DEC3X8_CNT_EN
  ,
  output logic [7:0]       count
`endif
);

  localparam int AW     = $clog2(DEPTH);
  localparam int MAXLEN = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int CW     = ($clog2(MAXLEN + 1) < 1) ? 1 : $clog2(MAXLEN + 1);

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [7:0]    out_nxt;
  logic [2:0]    mem [DEPTH];
  logic [AW:0]   wptr, rptr;
  logic          full, empty, push, pop;
  logic [7:0]    head_onehot;

  // The extra pointer bit tells full from empty when the index bits match.
  assign full         = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty        = (wptr == rptr);
  assign bus.in_ready = !full;
  assign push         = bus.in_valid && !full;
  assign head_onehot  = 8'b1 << mem[rptr[AW-1:0]];
  assign busy         = (state != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= bus.in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      out   <= 8'h00;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      out   <= out_nxt;
    end
  end

  // With no gap configured, a finished pulse can chain straight into the next code.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    out_nxt   = out;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        out_nxt = 8'h00;
        if (en && !empty) begin
          pop       = 1'b1;
          out_nxt   = head_onehot;
          cnt_nxt   = CW'(PULSE_LEN - 1);
          state_nxt = PULSE;
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          if (GAP_LEN > 0) begin
            out_nxt   = 8'h00;
            cnt_nxt   = CW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
            state_nxt = GAP;
          end else if (en && !empty) begin
            pop     = 1'b1;
            out_nxt = head_onehot;
            cnt_nxt = CW'(PULSE_LEN - 1);
          end else begin
            out_nxt   = 8'h00;
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      GAP: begin
        out_nxt = 8'h00;
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default: begin
        out_nxt   = 8'h00;
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef DEC3X8_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        count <= 8'h00;
    else if (pop && count != 8'hFF)    count <= count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_decoder_3x8_seq.sv
// Self-checking bench for decoder_3x8_seq: four parameterisations, scenario tasks, expected-output queue.
// The optional-count scenario is included when DEC3X8_CNT_EN is defined.
`timescale 1ns/1ps
module tb_decoder_3x8_seq;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  always #5 clk = ~clk;

  decoder_3x8_seq_if bus_a ();
  decoder_3x8_seq_if bus_b ();
  decoder_3x8_seq_if bus_c ();
  decoder_3x8_seq_if bus_d ();

  logic [7:0] out_a, out_b, out_c, out_d;
  logic       busy_a, busy_b, busy_c, busy_d;
`ifdef DEC3X8_CNT_EN
  logic [7:0] count_a, count_b, count_c, count_d;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] expq [$];

  // a: defaults, b: long pulses back-to-back, c: gap insertion, d: 4-cycle pulses.
  decoder_3x8_seq #(.DEPTH(4), .PULSE_LEN(1), .GAP_LEN(0)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .bus(bus_a), .out(out_a), .busy(busy_a)
`ifdef DEC3X8_CNT_EN
    , .count(count_a)
`endif
  );
  decoder_3x8_seq #(.DEPTH(4), .PULSE_LEN(2), .GAP_LEN(0)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .bus(bus_b), .out(out_b), .busy(busy_b)
`ifdef DEC3X8_CNT_EN
    , .count(count_b)
`endif
  );
  decoder_3x8_seq #(.DEPTH(4), .PULSE_LEN(1), .GAP_LEN(2)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en), .bus(bus_c), .out(out_c), .busy(busy_c)
`ifdef DEC3X8_CNT_EN
    , .count(count_c)
`endif
  );
  decoder_3x8_seq #(.DEPTH(4), .PULSE_LEN(4), .GAP_LEN(0)) u_d (
    .clk(clk), .rst_n(rst_n), .en(en), .bus(bus_d), .out(out_d), .busy(busy_d)
`ifdef DEC3X8_CNT_EN
    , .count(count_d)
`endif
  );

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (out_a !== 8'h00) begin errors++; $display("[TB] FAIL reset_out_a: got %h want 00", out_a); end
    checks++; if (bus_a.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready_a: got %b want 1", bus_a.in_ready); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy_a: got %b want 0", busy_a); end
    checks++; if ({out_b, out_c, out_d} !== 24'h0) begin errors++; $display("[TB] FAIL reset_out_bcd: got %h want 000000", {out_b, out_c, out_d}); end
    checks++; if ({busy_b, busy_c, busy_d} !== 3'b000) begin errors++; $display("[TB] FAIL reset_busy_bcd: got %b want 000", {busy_b, busy_c, busy_d}); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [7:0] exp;
    expq.delete();
    @(negedge clk);
    bus_a.in_valid = 1'b1; bus_a.in = 3'd5;
    expq.push_back(8'h20); expq.push_back(8'h00);
    checks++; if (bus_a.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_ready: got %b want 1", bus_a.in_ready); end
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    checks++; if (out_a !== 8'h00) begin errors++; $display("[TB] FAIL single_early: got %h want 00", out_a); end
    checks++; if (busy_a !== 1'b1) begin errors++; $display("[TB] FAIL single_busy: got %b want 1", busy_a); end
    while (expq.size() > 0) begin
      @(negedge clk);
      exp = expq.pop_front();
      checks++; if (out_a !== exp) begin errors++; $display("[TB] FAIL single_out: got %h want %h", out_a, exp); end
    end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("[TB] FAIL single_idle_busy: got %b want 0", busy_a); end
  endtask

  task automatic test_back_to_back();
    logic saw_full = 1'b0;
    int   guard;
    logic [7:0] exp;
    expq.delete();
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          bus_b.in_valid = 1'b1; bus_b.in = 3'(i);
          guard = 0;
          while (!bus_b.in_ready && guard < 50) begin
            saw_full = 1'b1;
            @(negedge clk);
            guard++;
          end
          expq.push_back(8'b1 << i); expq.push_back(8'b1 << i);
          @(posedge clk);
        end
        @(negedge clk);
        bus_b.in_valid = 1'b0;
        expq.push_back(8'h00);
      end
      begin
        int wait_cnt = 0;
        @(negedge clk);
        while (out_b === 8'h00 && wait_cnt < 20) begin @(negedge clk); wait_cnt++; end
        checks++; if (wait_cnt >= 20) begin errors++; $display("[TB] FAIL b2b_timeout: got no pulse want pulse"); end
        else begin
          for (int k = 0; k < 17; k++) begin
            if (expq.size() == 0) begin
              checks++; errors++; $display("[TB] FAIL b2b_extra: got %h want nothing queued", out_b);
            end else begin
              exp = expq.pop_front();
              checks++; if (out_b !== exp) begin errors++; $display("[TB] FAIL b2b_out[%0d]: got %h want %h", k, out_b, exp); end
            end
            @(negedge clk);
          end
        end
      end
    join
    checks++; if (saw_full !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_low: got %b want 1", saw_full); end
  endtask

  task automatic test_gap();
    int guard = 0;
    logic [7:0] exp;
    expq.delete();
    @(negedge clk);
    bus_c.in_valid = 1'b1; bus_c.in = 3'd3;
    expq.push_back(8'h08); expq.push_back(8'h00); expq.push_back(8'h00); expq.push_back(8'h00);
    @(negedge clk);
    bus_c.in = 3'd6;
    expq.push_back(8'h40); expq.push_back(8'h00); expq.push_back(8'h00);
    @(negedge clk);
    bus_c.in_valid = 1'b0;
    while (out_c === 8'h00 && guard < 20) begin @(negedge clk); guard++; end
    checks++; if (guard >= 20) begin errors++; $display("[TB] FAIL gap_timeout: got no pulse want pulse"); end
    while (expq.size() > 0) begin
      exp = expq.pop_front();
      checks++; if (out_c !== exp) begin errors++; $display("[TB] FAIL gap_out: got %h want %h", out_c, exp); end
      @(negedge clk);
    end
  endtask

  task automatic test_en_full();
    logic [2:0] codes [4] = '{3'd1, 3'd2, 3'd4, 3'd7};
    logic [7:0] exp;
    expq.delete();
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_a.in_valid = 1'b1; bus_a.in = codes[i];
      checks++; if (bus_a.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL en_push_ready[%0d]: got %b want 1", i, bus_a.in_ready); end
      exp = 8'b1 << codes[i];
      expq.push_back(exp);
      @(negedge clk);
    end
    checks++; if (bus_a.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL en_full_ready: got %b want 0", bus_a.in_ready); end
    bus_a.in = 3'd0;
    @(negedge clk);
    checks++; if (bus_a.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL en_full_hold: got %b want 0", bus_a.in_ready); end
    checks++; if (out_a !== 8'h00) begin errors++; $display("[TB] FAIL en_gated_out: got %h want 00", out_a); end
    checks++; if (busy_a !== 1'b1) begin errors++; $display("[TB] FAIL en_gated_busy: got %b want 1", busy_a); end
    bus_a.in_valid = 1'b0;
    en = 1'b1;
    expq.push_back(8'h00); expq.push_back(8'h00);
    @(negedge clk);
    checks++; if (bus_a.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL en_ready_rise: got %b want 1", bus_a.in_ready); end
    while (expq.size() > 0) begin
      exp = expq.pop_front();
      checks++; if (out_a !== exp) begin errors++; $display("[TB] FAIL en_out: got %h want %h", out_a, exp); end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    logic stray = 1'b0;
    int   guard = 0;
    @(negedge clk);
    bus_d.in_valid = 1'b1; bus_d.in = 3'd2;
    @(negedge clk);
    bus_d.in = 3'd3;
    @(negedge clk);
    bus_d.in_valid = 1'b0;
    checks++; if (out_d !== 8'h04) begin errors++; $display("[TB] FAIL arst_pulse: got %h want 04", out_d); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_d !== 8'h00) begin errors++; $display("[TB] FAIL arst_out: got %h want 00", out_d); end
    checks++; if (busy_d !== 1'b0) begin errors++; $display("[TB] FAIL arst_busy: got %b want 0", busy_d); end
    checks++; if (bus_d.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL arst_ready: got %b want 1", bus_d.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (out_d !== 8'h00 || busy_d !== 1'b0) stray = 1'b1;
    end
    checks++; if (stray !== 1'b0) begin errors++; $display("[TB] FAIL arst_stale: got activity want none"); end
    bus_d.in_valid = 1'b1; bus_d.in = 3'd6;
    @(negedge clk);
    bus_d.in_valid = 1'b0;
    while (out_d === 8'h00 && guard < 10) begin @(negedge clk); guard++; end
    checks++; if (out_d !== 8'h40) begin errors++; $display("[TB] FAIL arst_next: got %h want 40", out_d); end
    repeat (6) @(negedge clk);
  endtask

`ifdef DEC3X8_CNT_EN
  task automatic test_count();
    int guard;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (count_a !== 8'h00) begin errors++; $display("[TB] FAIL cnt_start: got %h want 00", count_a); end
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < ((r == 0) ? 260 : 3); i++) begin
        @(negedge clk);
        bus_a.in_valid = 1'b1; bus_a.in = 3'(i);
        guard = 0;
        while (!bus_a.in_ready && guard < 50) begin @(negedge clk); guard++; end
        @(posedge clk);
      end
      @(negedge clk);
      bus_a.in_valid = 1'b0;
      guard = 0;
      while (busy_a && guard < 50) begin @(negedge clk); guard++; end
      checks++; if (count_a !== 8'hFF) begin errors++; $display("[TB] FAIL cnt_sat[%0d]: got %h want ff", r, count_a); end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (count_a !== 8'h00) begin errors++; $display("[TB] FAIL cnt_reset: got %h want 00", count_a); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    bus_a.in_valid = 1'b0; bus_a.in = 3'd0;
    bus_b.in_valid = 1'b0; bus_b.in = 3'd0;
    bus_c.in_valid = 1'b0; bus_c.in = 3'd0;
    bus_d.in_valid = 1'b0; bus_d.in = 3'd0;
    $display("[TB] starting decoder_3x8_seq bench");
    test_reset();
    test_single();
    test_back_to_back();
    test_gap();
    test_en_full();
    test_async_reset();
`ifdef DEC3X8_CNT_EN
    test_count();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder_3x8_seq.md
Name: decoder_3x8_seq

Overview:
- Sequenced 3-to-8 one-hot decoder, the inverse of the team's 8x3 encoder.
- Accepts 3-bit codes over a valid/ready handshake and buffers them in a small FIFO.
- Drives each code onto an 8-bit one-hot output as a timed pulse, with a programmable gap between pulses.
- Used to drive per-line strobes (chip selects, LED/row scan, interrupt acks) from a serialized code stream.

Parameters:
- DEPTH, 4: FIFO entries (power of 2, >=2).
- PULSE_LEN, 1: cycles each one-hot pattern is held (>=1).
- GAP_LEN, 0: all-zero cycles inserted after each pulse (>=0).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  permits the FSM to start a new pulse
- in_valid  input  1  in[2:0] holds a valid code
- in_ready  output  1  FIFO can accept; equals !full
- in  input  3  binary code 0..7
- out  output  8  registered one-hot pattern, or all zero
- busy  output  1  FSM not IDLE or FIFO non-empty

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (rst_n).
  - While rst_n=0: out=8'h00, FIFO empty, in_ready=1, busy=0, FSM=IDLE, counters=0.
  - Asserting rst_n mid-pulse clears immediately, without waiting for a clock edge; buffered codes are lost.
- FIFO:
  - Push when in_valid && in_ready at a rising edge.
  - in_ready is derived from registered full only. When full, no push occurs even if a pop happens the same cycle.
  - Pop is performed only by the FSM.
  - Read/write pointers are log2(DEPTH) bits, wrap modulo DEPTH, and use an extra wrap bit (or count) for full/empty.
- Decode: out = 8'b1 << code, so code 0 -> 8'h01 and code 7 -> 8'h80. Exactly one bit is set during PULSE; out is 8'h00 otherwise.
- FSM states: IDLE, PULSE, GAP.
  - IDLE: out=0. If en && !empty, pop, load out with the decoded code, set cnt=PULSE_LEN-1, go to PULSE.
  - PULSE: hold out. When cnt==0:
    - If GAP_LEN>0: out=0, cnt=GAP_LEN-1, go to GAP.
    - Else if en && !empty: pop the next code and load it directly (back-to-back, no zero cycle), staying in PULSE.
    - Else: out=0, go to IDLE.
    - Otherwise decrement cnt.
  - GAP: out=0. When cnt==0, go to IDLE; else decrement. The next pop happens from IDLE (one extra cycle).
- Latency: a code accepted at edge t, with FIFO empty, FSM in IDLE and en=1, appears on out after edge t+1. It is held exactly PULSE_LEN cycles.
- en deasserted:
  - A pulse in progress completes normally, including its gap.
  - No new pop occurs; the FIFO continues accepting codes until full.
- Simultaneous push and pop on a non-full FIFO: both occur, and occupancy is unchanged.
- Codes are emitted in strict arrival order; none are dropped or duplicated.
- Counter width = clog2(max(PULSE_LEN, GAP_LEN)+1), minimum 1 bit.
- busy = (state!=IDLE) || !empty, registered-equivalent, no glitch paths to in_ready.

Optional Feature:
- Macro DEC3X8_CNT_EN.
- When defined:
  - Adds output port count, 8 bits, reset 8'h00.
  - count increments on every FSM pop and saturates at 8'hFF (no wrap).
  - Reset clears it asynchronously.
- When undefined: the port and logic are absent, and all other behaviour is identical.

Test Plan:
- Reset and single code, defaults: hold rst_n=0, check out=00, in_ready=1, busy=0. Release, push code 5 at edge t. Check out=8'h20 after edge t+1 for 1 cycle, then 00; busy drops once IDLE.
- Full sweep, back-to-back, PULSE_LEN=2, GAP_LEN=0: push 0..7 with in_valid held. Check out=01,01,02,02,...,80,80 with no zero cycles between. Check in_ready deasserts while 4 entries are pending, and order is preserved.
- Gap insertion, PULSE_LEN=1, GAP_LEN=2: push 3 then 6. Check out=08, 00, 00, 00 (IDLE), 40, then zeros.
- en gating and full FIFO: en=0, push 1,2,4,7. Check in_ready=0 after the 4th push; a 5th in_valid with code 0 is not accepted. Set en=1: check out=02,04,10,80; in_ready rises after the first pop.
- Async reset mid-pulse, PULSE_LEN=4: push 2 and 3, assert rst_n low at mid-cycle during the 08'h04 pulse. Check out=00 immediately (before the next edge), FIFO empty, and code 3 is never emitted after release.
- With DEC3X8_CNT_EN: push 260 codes. Check count=255 and that it stays at 255; reset returns it to 0.
